// File: rtl/processing_grid_pkg.sv
// Shared types and constants for the 12x12 stencil processing grid.
// Holds grid sizes, coefficient/tile types, the position record and
// the fixed-point helpers used by every processing element.
package processing_grid_pkg;

    localparam int c_datawidth     = 32;
    localparam int c_innergridsize = 6;
    localparam int c_outergridsize = 2;

    localparam int c_gridsize   = c_innergridsize * c_outergridsize;
    localparam int c_ncoeff     = 13;
    localparam int c_pointcount = c_innergridsize * c_innergridsize;
    localparam int c_posw       = $clog2(c_innergridsize);
    localparam int c_accwidth   = 56;

    // Pickup point and unit impulse in Q16.16
    localparam int c_pickx = 2;
    localparam int c_picky = 2;

    typedef logic signed [c_datawidth-1:0] t_data;
    typedef logic signed [c_accwidth-1:0]  t_acc;

    localparam t_data c_unit = 32'sh0001_0000;

    typedef t_data t_coefficients [0:c_ncoeff-1];
    typedef t_data t_stencil      [0:c_ncoeff-1];
    typedef t_data t_tile [0:c_innergridsize-1][0:c_innergridsize-1];

    typedef struct packed {
        logic [c_posw-1:0] x;
        logic [c_posw-1:0] y;
    } t_position;

    typedef enum logic [1:0] {
        S_POINT,
        S_SWAP,
        S_OUTPUT
    } t_phase;

    // Radius-2 diamond, rows dy=-2..2
    localparam int c_offx [0:c_ncoeff-1] =
        '{0, -1, 0, 1, -2, -1, 0, 1, 2, -1, 0, 1, 0};
    localparam int c_offy [0:c_ncoeff-1] =
        '{-2, -1, -1, -1, 0, 0, 0, 0, 0, 1, 1, 1, 2};

    // Q16.16 product: full 64-bit signed result, arithmetic >> 16
    function automatic t_acc scaled_product(t_data a, t_data b);
        logic signed [2*c_datawidth-1:0] p;
        p = 64'(a) * 64'(b);
        return t_acc'(p >>> 16);
    endfunction

    // Clamp the wide accumulator into the 32-bit signed range
    function automatic t_data saturate(t_acc a);
        logic [c_accwidth-c_datawidth:0] top;
        top = a[c_accwidth-1:c_datawidth-1];
        if (top == '0 || top == '1) begin
            return a[c_datawidth-1:0];
        end
        if (a[c_accwidth-1]) begin
            return {1'b1, {(c_datawidth-1){1'b0}}};
        end
        return {1'b0, {(c_datawidth-1){1'b1}}};
    endfunction

endpackage

// File: rtl/processing_grid_element.sv
// One 6x6 tile of the grid: holds u_n, u_nm1 and the next-step buffer.
// Ports: clock/async reset, coefficients, 13-point halo values for the
// current position, control (position/compute/swap); exports the tile
// contents for neighbour halo reads and the current point result.
module processing_element
    import processing_grid_pkg::*;
#(
    parameter int p_tilex = 0,
    parameter int p_tiley = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  t_coefficients i_coefficientsN,
    input  t_coefficients i_coefficientsNMinus1,
    input  t_stencil      i_haloN,
    input  t_stencil      i_haloNMinus1,
    input  t_position     i_position,
    input  logic          i_compute,
    input  logic          i_swap,
    output t_tile         o_tileN,
    output t_tile         o_tileNMinus1,
    output t_data         o_currentOutput,
    output logic          o_currentValid,
    output t_position     o_currentPosition
);

    t_tile tile_n;
    t_tile tile_nm1;
    t_tile tile_next;
    t_acc  acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < c_ncoeff; k++) begin
            acc = acc
                + scaled_product(i_coefficientsN[k], i_haloN[k])
                + scaled_product(i_coefficientsNMinus1[k],
                                 i_haloNMinus1[k]);
        end
    end

    assign o_currentOutput   = saturate(acc);
    assign o_currentValid    = i_compute;
    assign o_currentPosition = i_position;
    assign o_tileN           = tile_n;
    assign o_tileNMinus1     = tile_nm1;

    // Results collect in tile_next; the whole grid commits at once
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int lx = 0; lx < c_innergridsize; lx++) begin
                for (int ly = 0; ly < c_innergridsize; ly++) begin
                    if ((p_tilex * c_innergridsize + lx == c_pickx) &&
                        (p_tiley * c_innergridsize + ly == c_picky)) begin
                        tile_n[lx][ly] <= c_unit;
                    end else begin
                        tile_n[lx][ly] <= '0;
                    end
                    tile_nm1[lx][ly]  <= '0;
                    tile_next[lx][ly] <= '0;
                end
            end
        end else begin
            if (i_compute) begin
                tile_next[i_position.x][i_position.y] <= o_currentOutput;
            end
            if (i_swap) begin
                tile_nm1 <= tile_n;
                tile_n   <= tile_next;
            end
        end
    end

endmodule

// File: rtl/processing_grid.sv
// 12x12 Q16.16 radius-2 stencil grid built from 2x2 processing elements.
// Ports: i_clk, i_reset (async, active-low), i_coefficientsN/NMinus1
// (13 weights each); o_outputReady pulses once per step with o_output.
module processing_grid
    import processing_grid_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    input  t_coefficients i_coefficientsN,
    input  t_coefficients i_coefficientsNMinus1,
    output logic          o_outputReady,
    output t_data         o_output
);

    localparam logic [c_posw-1:0] c_poslast = c_posw'(c_innergridsize - 1);

    t_phase    state;
    t_phase    state_next;
    t_position pos;
    t_position pos_next;
    logic      compute;
    logic      swap;
    logic      emit;

    t_data grid_n   [0:c_gridsize-1][0:c_gridsize-1];
    t_data grid_nm1 [0:c_gridsize-1][0:c_gridsize-1];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_POINT;
            pos   <= '0;
        end else begin
            state <= state_next;
            pos   <= pos_next;
        end
    end

    // 36 point cycles in raster order (x outer), then swap, then output
    always_comb begin
        state_next = state;
        pos_next   = pos;
        compute    = 1'b0;
        swap       = 1'b0;
        emit       = 1'b0;
        unique case (state)
            S_POINT: begin
                compute = 1'b1;
                if (pos.y == c_poslast) begin
                    pos_next.y = '0;
                    if (pos.x == c_poslast) begin
                        pos_next.x = '0;
                        state_next = S_SWAP;
                    end else begin
                        pos_next.x = pos.x + 1'b1;
                    end
                end else begin
                    pos_next.y = pos.y + 1'b1;
                end
            end
            S_SWAP: begin
                swap       = 1'b1;
                state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                emit       = 1'b1;
                state_next = S_POINT;
            end
            default: state_next = S_POINT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_outputReady <= 1'b0;
            o_output      <= '0;
        end else begin
            o_outputReady <= emit;
            if (emit) begin
                o_output <= grid_n[c_pickx][c_picky];
            end
        end
    end

    for (genvar gx = 0; gx < c_outergridsize; gx++) begin : gen_outer
        for (genvar gy = 0; gy < c_outergridsize; gy++) begin : gen_inner
            t_tile     pe_tile_n;
            t_tile     pe_tile_nm1;
            t_stencil  halo_n;
            t_stencil  halo_nm1;
            t_data     cur_out;
            logic      cur_valid;
            t_position cur_pos;
            logic      unused_cur;

            assign unused_cur = ^{cur_out, cur_valid};

            for (genvar lx = 0; lx < c_innergridsize; lx++) begin : gen_mx
                for (genvar ly = 0; ly < c_innergridsize; ly++) begin : gen_my
                    assign grid_n[gx*c_innergridsize+lx]
                                 [gy*c_innergridsize+ly] = pe_tile_n[lx][ly];
                    assign grid_nm1[gx*c_innergridsize+lx]
                                   [gy*c_innergridsize+ly] = pe_tile_nm1[lx][ly];
                end
            end

            // Halo reads may land in any tile; outside the grid reads 0
            always_comb begin
                for (int k = 0; k < c_ncoeff; k++) begin
                    int nx;
                    int ny;
                    nx = gx * c_innergridsize + int'(cur_pos.x) + c_offx[k];
                    ny = gy * c_innergridsize + int'(cur_pos.y) + c_offy[k];
                    halo_n[k]   = '0;
                    halo_nm1[k] = '0;
                    if (nx >= 0 && nx < c_gridsize &&
                        ny >= 0 && ny < c_gridsize) begin
                        halo_n[k]   = grid_n[nx][ny];
                        halo_nm1[k] = grid_nm1[nx][ny];
                    end
                end
            end

            processing_element #(
                .p_tilex (gx),
                .p_tiley (gy)
            ) u_pe (
                .i_clk                 (i_clk),
                .i_reset               (i_reset),
                .i_coefficientsN       (i_coefficientsN),
                .i_coefficientsNMinus1 (i_coefficientsNMinus1),
                .i_haloN               (halo_n),
                .i_haloNMinus1         (halo_nm1),
                .i_position            (pos),
                .i_compute             (compute),
                .i_swap                (swap),
                .o_tileN               (pe_tile_n),
                .o_tileNMinus1         (pe_tile_nm1),
                .o_currentOutput       (cur_out),
                .o_currentValid        (cur_valid),
                .o_currentPosition     (cur_pos)
            );
        end
    end

endmodule

// File: tb/tb_processing_grid.sv
// Self-checking bench for processing_grid against a 12x12 array model.
// Checks reset, pulse timing, fixed vectors, saturation, cross-tile data.
module tb_processing_grid;
    import processing_grid_pkg::*;

    localparam int c_step = c_pointcount + 2;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    t_coefficients cn;
    t_coefficients cnm1;
    logic          o_outputReady;
    t_data         o_output;

    int checks = 0;
    int errors = 0;

    longint mn   [0:c_gridsize-1][0:c_gridsize-1];
    longint mnm1 [0:c_gridsize-1][0:c_gridsize-1];
    longint mnx  [0:c_gridsize-1][0:c_gridsize-1];
    t_data  pulses [$];

    int dxs [0:12] = '{0, -1, 0, 1, -2, -1, 0, 1, 2, -1, 0, 1, 0};
    int dys [0:12] = '{-2, -1, -1, -1, 0, 0, 0, 0, 0, 1, 1, 1, 2};

    processing_grid dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_coefficientsN       (cn),
        .i_coefficientsNMinus1 (cnm1),
        .o_outputReady         (o_outputReady),
        .o_output              (o_output)
    );

    always #5 i_clk = ~i_clk;

    function automatic longint model_point(int x, int y);
        longint s = 0;
        for (int k = 0; k < 13; k++) begin
            int nx = x + dxs[k];
            int ny = y + dys[k];
            if (nx >= 0 && nx < 12 && ny >= 0 && ny < 12) begin
                s += (longint'(cn[k]) * mn[nx][ny]) >>> 16;
                s += (longint'(cnm1[k]) * mnm1[nx][ny]) >>> 16;
            end
        end
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    task automatic model_reset();
        for (int x = 0; x < 12; x++)
            for (int y = 0; y < 12; y++) begin
                mn[x][y] = 0;
                mnm1[x][y] = 0;
            end
        mn[2][2] = 65536;
    endtask

    task automatic model_step();
        for (int x = 0; x < 12; x++)
            for (int y = 0; y < 12; y++)
                mnx[x][y] = model_point(x, y);
        mnm1 = mn;
        mn = mnx;
    endtask

    task automatic clear_coeffs();
        for (int k = 0; k < 13; k++) begin
            cn[k] = '0;
            cnm1[k] = '0;
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_outputReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", o_outputReady);
        end
        checks++;
        if (o_output !== 32'h0) begin
            errors++;
            $display("FAIL reset_output: got %h expected 0", o_output);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        model_reset();
        pulses.delete();
    endtask

    // Starts at cycle 0 of a step; walks n steps and checks the pulse
    // that opens the following step.
    task automatic run_steps(input int n, input bit check_el);
        for (int s = 0; s <= n; s++) begin
            for (int c = 0; c < c_step; c++) begin
                checks++;
                if (c == 0 && s > 0) begin
                    if (o_outputReady !== 1'b1) begin
                        errors++;
                        $display("FAIL pulse_ready step %0d: got %b expected 1",
                                 s, o_outputReady);
                    end else begin
                        pulses.push_back(o_output);
                        checks++;
                        if (o_output !== 32'(mn[2][2])) begin
                            errors++;
                            $display("FAIL pulse_value step %0d: got %h expected %h",
                                     s, o_output, 32'(mn[2][2]));
                        end
                    end
                end else if (o_outputReady !== 1'b0) begin
                    errors++;
                    $display("FAIL pulse_spacing step %0d cyc %0d: got 1 expected 0",
                             s, c);
                end
                if (s == n) return;
                if (check_el && c < c_pointcount) begin
                    int x = c / c_innergridsize;
                    int y = c % c_innergridsize;
                    t_position ep;
                    t_data ev;
                    ep.x = c_posw'(x);
                    ep.y = c_posw'(y);
                    ev = 32'(model_point(c_innergridsize + x, y));
                    checks++;
                    if (dut.gen_outer[1].gen_inner[0].u_pe.o_currentOutput
                        !== ev) begin
                        errors++;
                        $display("FAIL el10_value (%0d,%0d): got %h expected %h",
                                 x, y,
                                 dut.gen_outer[1].gen_inner[0].u_pe.o_currentOutput,
                                 ev);
                    end
                    checks++;
                    if (dut.gen_outer[1].gen_inner[0].u_pe.o_currentPosition
                        !== ep ||
                        dut.gen_outer[1].gen_inner[0].u_pe.o_currentValid
                        !== 1'b1) begin
                        errors++;
                        $display("FAIL el10_pos cyc %0d: got %h expected %h",
                                 c,
                                 dut.gen_outer[1].gen_inner[0].u_pe.o_currentPosition,
                                 ep);
                    end
                end
                @(posedge i_clk);
                #1;
            end
            model_step();
        end
    endtask

    task automatic test_reset();
        clear_coeffs();
        do_reset();
        run_steps(1, 1'b0);
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("FAIL reset_first_pulse: got %0d pulses expected 1",
                     pulses.size());
        end
    endtask

    task automatic set_wave();
        clear_coeffs();
        cn[2] = 32'h0000_7EE3;
        cn[5] = 32'h0000_7EE3;
        cn[7] = 32'h0000_7EE3;
        cn[10] = 32'h0000_7EE3;
        cn[6] = 32'h0000_045F;
        cnm1[6] = 32'hFFFF_0015;
    endtask

    task automatic test_wave();
        set_wave();
        do_reset();
        run_steps(2, 1'b1);
        checks++;
        if (pulses.size() != 2 || pulses[0] !== 32'h0000_045F ||
            pulses[1] !== 32'hFFFF_FBB8) begin
            errors++;
            $display("FAIL wave_fixed: got %0d pulses first %h expected 045f,fffffbb8",
                     pulses.size(), pulses.size() > 0 ? pulses[0] : 32'h0);
        end
    endtask

    task automatic test_identity();
        clear_coeffs();
        cn[6] = 32'h0001_0000;
        do_reset();
        run_steps(10, 1'b0);
        checks++;
        if (pulses.size() != 10) begin
            errors++;
            $display("FAIL identity_count: got %0d expected 10", pulses.size());
        end
        foreach (pulses[i]) begin
            checks++;
            if (pulses[i] !== 32'h0001_0000) begin
                errors++;
                $display("FAIL identity_value %0d: got %h expected 00010000",
                         i, pulses[i]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_coeffs();
        cn[6] = 32'h7FFF_FFFF;
        do_reset();
        run_steps(2, 1'b1);
        checks++;
        if (pulses.size() != 2 || pulses[0] !== 32'h7FFF_FFFF ||
            pulses[1] !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL saturation: got %0d pulses expected 2 x 7fffffff",
                     pulses.size());
        end
    endtask

    task automatic test_cross_tile();
        clear_coeffs();
        cn[4] = 32'h0001_0000;
        cn[8] = 32'h0001_0000;
        do_reset();
        run_steps(3, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 13; k++) begin
                int a = int'($urandom_range(0, 65535)) - 32768;
                int b = int'($urandom_range(0, 131071)) - 65536;
                cn[k] = (r == 2) ? t_data'($urandom) : t_data'(a);
                cnm1[k] = t_data'(b);
            end
            do_reset();
            run_steps(3, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        set_wave();
        do_reset();
        repeat (20) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_outputReady !== 1'b0 || o_output !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_async: got %b/%h expected 0/0",
                     o_outputReady, o_output);
        end
        do_reset();
        run_steps(1, 1'b1);
        checks++;
        if (pulses.size() != 1 || pulses[0] !== 32'h0000_045F) begin
            errors++;
            $display("FAIL mid_reset_restart: got %0d pulses expected 1 x 0000045f",
                     pulses.size());
        end
    endtask

    initial begin
        clear_coeffs();
        model_reset();
        test_reset();
        test_wave();
        test_identity();
        test_saturation();
        test_cross_tile();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
